// File: rtl/ahb_mem_slave.sv
// AHB-Lite SRAM responder backing the cache downstream port.
// Programmable wait states, byte lanes, two-cycle ERROR, backdoor preload.
module ahb_mem_slave #(
  parameter int          MEM_WORDS  = 4096,
  parameter logic [31:0] BASE_ADDR  = 32'h0000_0000,
  parameter int          FIRST_WAIT = 1,
  parameter int          SEQ_WAIT   = 0
) (
  input  logic                         hclk,
  input  logic                         hrst,
  input  logic                         hsel,
  input  logic [31:0]                  haddr,
  input  logic [1:0]                   htrans,
  input  logic                         hwrite,
  input  logic [2:0]                   hsize,
  input  logic [2:0]                   hburst,
  input  logic [31:0]                  hwdata,
  input  logic                         hready,
  output logic                         hreadyout,
  output logic                         hresp,
  output logic [31:0]                  hrdata,
  input  logic                         load_en,
  input  logic [$clog2(MEM_WORDS)-1:0] load_addr,
  input  logic [31:0]                  load_data
);

  localparam int          AW      = $clog2(MEM_WORDS);
  localparam logic [31:0] SPAN    = 32'(MEM_WORDS) << 2;
  localparam logic [31:0] HI_MASK = ~(SPAN - 32'd1);
  localparam logic [3:0]  FW      = 4'(FIRST_WAIT);
  localparam logic [3:0]  SW      = 4'(SEQ_WAIT);

  typedef enum logic [2:0] {
    S_IDLE, S_WAIT, S_DATA, S_ERR1, S_ERR2
  } state_t;

  logic [31:0] mem [MEM_WORDS];

  state_t        state, state_nx;
  logic [3:0]    cnt;
  logic [AW-1:0] cap_idx;
  logic [1:0]    cap_lo;
  logic [2:0]    cap_size;
  logic          cap_write;

  logic          open_st, accept;
  logic          in_range, misalign, illegal;
  logic [3:0]    wait_ld;
  logic [AW-1:0] acc_idx, rd_idx;
  logic [3:0]    be;
  logic [31:0]   wr_word;
  logic          wr_go, rd_go;
  logic          unused_hburst;

  assign unused_hburst = ^hburst;

  assign open_st  = state inside {S_IDLE, S_DATA, S_ERR2};
  assign accept   = open_st & hsel & hready & htrans[1];
  assign in_range = (haddr & HI_MASK) == BASE_ADDR;
  assign misalign = (hsize == 3'd1 && haddr[0])
                  | (hsize == 3'd2 && haddr[1:0] != 2'd0);
  assign illegal  = !in_range | (hsize > 3'd2) | misalign;
  assign wait_ld  = htrans[0] ? SW : FW;
  assign acc_idx  = haddr[AW+1:2];

  always_ff @(posedge hclk) begin
    if (hrst) state <= S_IDLE;
    else      state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      S_WAIT:  if (cnt == 4'd1) state_nx = S_DATA;
      S_ERR1:  state_nx = S_ERR2;
      default: begin
        if (!accept)             state_nx = S_IDLE;
        else if (illegal)        state_nx = S_ERR1;
        else if (wait_ld != '0)  state_nx = S_WAIT;
        else                     state_nx = S_DATA;
      end
    endcase
  end

  always_comb begin
    hreadyout = 1'b1;
    hresp     = 1'b0;
    unique case (state)
      S_WAIT:  hreadyout = 1'b0;
      S_ERR1: begin
        hreadyout = 1'b0;
        hresp     = 1'b1;
      end
      S_ERR2:  hresp = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge hclk) begin
    if (hrst) begin
      cnt       <= '0;
      cap_idx   <= '0;
      cap_lo    <= '0;
      cap_size  <= '0;
      cap_write <= 1'b0;
    end else if (accept) begin
      cnt       <= wait_ld;
      cap_idx   <= acc_idx;
      cap_lo    <= haddr[1:0];
      cap_size  <= hsize;
      cap_write <= hwrite;
    end else if (state == S_WAIT) begin
      cnt <= cnt - 4'd1;
    end
  end

  always_comb begin
    be = 4'hf;
    unique case (1'b1)
      cap_size == 3'd0: be = 4'b0001 << cap_lo;
      cap_size == 3'd1: be = cap_lo[1] ? 4'b1100 : 4'b0011;
      default:          be = 4'hf;
    endcase
  end

  always_comb begin
    wr_word = mem[cap_idx];
    for (int k = 0; k < 4; k++)
      if (be[k]) wr_word[8*k +: 8] = hwdata[8*k +: 8];
  end

  assign wr_go  = (state == S_DATA) & cap_write;
  assign rd_go  = ((state == S_WAIT) & (cnt == 4'd1) & !cap_write)
                | (accept & !illegal & (wait_ld == '0) & !hwrite);
  assign rd_idx = (state == S_WAIT) ? cap_idx : acc_idx;

  always_ff @(posedge hclk) begin
    if (!hrst) begin
      if (wr_go)
        mem[cap_idx] <= wr_word;
      else if (state == S_IDLE && load_en)
        mem[load_addr] <= load_data;
    end
  end

  // A read entering DATA while the same word's write completes sees the merged word
  always_ff @(posedge hclk) begin
    if (hrst)
      hrdata <= '0;
    else if (rd_go)
      hrdata <= (wr_go && cap_idx == rd_idx) ? wr_word : mem[rd_idx];
  end

endmodule

// File: tb/tb_ahb_mem_slave.sv
// Bench for ahb_mem_slave: pipelined AHB master driver,
// scoreboard queue of expected responses, memory reference model.
module tb_ahb_mem_slave;

  logic        hclk = 1'b0;
  logic        hrst = 1'b1;
  logic        hsel = 1'b0;
  logic [31:0] haddr = '0;
  logic [1:0]  htrans = '0;
  logic        hwrite = 1'b0;
  logic [2:0]  hsize = '0;
  logic [2:0]  hburst = '0;
  logic [31:0] hwdata = '0;
  logic        hready;
  logic        hreadyout;
  logic        hresp;
  logic [31:0] hrdata;
  logic        load_en = 1'b0;
  logic [11:0] load_addr = '0;
  logic [31:0] load_data = '0;

  assign hready = hreadyout;

  always #5 hclk = ~hclk;

  ahb_mem_slave #(
    .MEM_WORDS (4096),
    .BASE_ADDR (32'h0),
    .FIRST_WAIT(1),
    .SEQ_WAIT  (0)
  ) dut (
    .hclk     (hclk),
    .hrst     (hrst),
    .hsel     (hsel),
    .haddr    (haddr),
    .htrans   (htrans),
    .hwrite   (hwrite),
    .hsize    (hsize),
    .hburst   (hburst),
    .hwdata   (hwdata),
    .hready   (hready),
    .hreadyout(hreadyout),
    .hresp    (hresp),
    .hrdata   (hrdata),
    .load_en  (load_en),
    .load_addr(load_addr),
    .load_data(load_data)
  );

  typedef struct {
    logic [31:0] a;
    logic        w;
    logic [2:0]  s;
    logic [1:0]  t;
    logic [31:0] d;
  } beat_t;

  typedef struct {
    logic        rd;
    logic        err;
    logic [31:0] data;
  } exp_t;

  beat_t       cmd [$];
  exp_t        exp_q [$];
  logic [31:0] model [0:4095];
  int          errors = 0;
  int          checks = 0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, want);
    end
  endtask

  task automatic add(input logic [31:0] a, input logic w,
                     input logic [2:0] s, input logic [1:0] t,
                     input logic [31:0] d);
    beat_t b;
    b.a = a; b.w = w; b.s = s; b.t = t; b.d = d;
    cmd.push_back(b);
  endtask

  task automatic predict(input beat_t b);
    exp_t        e;
    logic [3:0]  lanes;
    logic [11:0] wi;
    e.rd   = !b.w;
    e.err  = (b.a >= 32'h4000) || (b.s > 3'd2)
           || (b.s == 3'd1 && b.a[0])
           || (b.s == 3'd2 && b.a[1:0] != 2'd0);
    e.data = '0;
    wi     = b.a[13:2];
    if (!e.err) begin
      if (b.w) begin
        if (b.s == 3'd0)      lanes = 4'b0001 << b.a[1:0];
        else if (b.s == 3'd1) lanes = b.a[1] ? 4'b1100 : 4'b0011;
        else                  lanes = 4'hf;
        for (int k = 0; k < 4; k++)
          if (lanes[k]) model[wi][8*k +: 8] = b.d[8*k +: 8];
      end else begin
        e.data = model[wi];
      end
    end
    exp_q.push_back(e);
  endtask

  task automatic drive_addr(input beat_t b);
    hsel   = 1'b1;
    haddr  = b.a;
    hwrite = b.w;
    hsize  = b.s;
    htrans = b.t;
  endtask

  task automatic drive_idle();
    hsel   = 1'b0;
    haddr  = '0;
    hwrite = 1'b0;
    hsize  = '0;
    htrans = 2'd0;
  endtask

  task automatic run(input string tag, input int want_stalls);
    int   i = 0;
    int   stalls = 0;
    int   cyc = 0;
    bit   dp = 1'b0;
    bit   rdy;
    exp_t e;
    drive_addr(cmd[0]);
    while (i < cmd.size() || dp) begin
      @(negedge hclk);
      rdy = hreadyout;
      cyc++;
      if (dp) begin
        e = exp_q[0];
        if (!rdy) begin
          stalls++;
          chk({tag, "/stall_resp"}, 32'(hresp), 32'(e.err));
        end else begin
          chk({tag, "/resp"}, 32'(hresp), 32'(e.err));
          if (e.rd && !e.err)
            chk({tag, "/rdata"}, hrdata, e.data);
        end
      end
      if (cyc > 100) begin
        chk({tag, "/timeout"}, 32'(cyc), 32'd100);
        break;
      end
      @(posedge hclk);
      #1;
      if (rdy) begin
        if (dp) void'(exp_q.pop_front());
        dp = 1'b0;
        if (i < cmd.size()) begin
          predict(cmd[i]);
          hwdata = cmd[i].w ? cmd[i].d : 32'h0;
          dp = 1'b1;
          i++;
          if (i < cmd.size()) drive_addr(cmd[i]);
          else                drive_idle();
        end
      end
    end
    drive_idle();
    chk({tag, "/stalls"}, 32'(stalls), 32'(want_stalls));
    cmd.delete();
    exp_q.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    repeat (2) @(posedge hclk);
    @(negedge hclk);
    chk("rst_ready", 32'(hreadyout), 32'd1);
    chk("rst_resp", 32'(hresp), 32'd0);
    chk("rst_rdata", hrdata, 32'd0);
    @(posedge hclk);
    #1 hrst = 1'b0;

    for (int k = 0; k < 4; k++) begin
      load_en   = 1'b1;
      load_addr = 12'(k);
      load_data = 32'((k + 1) * 32'h11);
      model[k]  = 32'((k + 1) * 32'h11);
      @(posedge hclk);
      #1;
    end
    load_en = 1'b0;

    add(32'h4, 1'b0, 3'd2, 2'd2, 32'h0);
    run("rd4", 1);

    add(32'h8, 1'b0, 3'd2, 2'd2, 32'h0);
    add(32'hC, 1'b0, 3'd2, 2'd3, 32'h0);
    add(32'h0, 1'b0, 3'd2, 2'd3, 32'h0);
    add(32'h4, 1'b0, 3'd2, 2'd3, 32'h0);
    run("wrap4", 1);

    add(32'h5, 1'b1, 3'd0, 2'd2, {4{8'hAB}});
    add(32'h4, 1'b0, 3'd2, 2'd3, 32'h0);
    run("raw_byte", 1);

    add(32'h4000, 1'b0, 3'd2, 2'd2, 32'h0);
    run("oor_rd", 1);
    add(32'h4000, 1'b1, 3'd2, 2'd2, 32'hDEAD_BEEF);
    run("oor_wr", 1);
    add(32'h0, 1'b0, 3'd2, 2'd2, 32'h0);
    run("post_oor", 1);

    add(32'h9, 1'b1, 3'd1, 2'd2, 32'hFFFF_FFFF);
    add(32'h8, 1'b0, 3'd2, 2'd2, 32'h0);
    run("mis_half", 2);

    add(32'h0, 1'b0, 3'd3, 2'd2, 32'h0);
    add(32'hA, 1'b1, 3'd1, 2'd2, 32'hBEEF_0000);
    add(32'h8, 1'b0, 3'd2, 2'd3, 32'h0);
    run("size3_half", 2);

    hsel   = 1'b1;
    haddr  = 32'hC;
    hwrite = 1'b1;
    hsize  = 3'd2;
    htrans = 2'd2;
    @(posedge hclk);
    #1;
    hwdata = 32'hCAFE_F00D;
    drive_idle();
    @(negedge hclk);
    chk("rst_wr/wait", 32'(hreadyout), 32'd0);
    hrst = 1'b1;
    @(posedge hclk);
    #1 hrst = 1'b0;
    @(negedge hclk);
    chk("rst_wr/ready", 32'(hreadyout), 32'd1);
    chk("rst_wr/resp", 32'(hresp), 32'd0);
    @(posedge hclk);
    #1;
    add(32'hC, 1'b0, 3'd2, 2'd2, 32'h0);
    run("post_rst", 1);

    load_en   = 1'b1;
    load_addr = 12'd5;
    load_data = 32'h5555_AAAA;
    model[5]  = 32'h5555_AAAA;
    @(posedge hclk);
    #1 load_en = 1'b0;
    add(32'h14, 1'b0, 3'd2, 2'd2, 32'h0);
    run("backdoor", 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ahb_mem_slave.md
Name: ahb_mem_slave

Overview:
- AHB-Lite responder modelling the instruction/data backing memory that sits on the cache's downstream port.
- Implements word-addressed SRAM storage with a configurable wait-state count per beat.
- Supports byte-lane writes and the full AHB-Lite two-cycle ERROR response.
- Accepts single transfers and INCR/INCR4/WRAP4 bursts issued by the cache refill path.

Parameters:
- MEM_WORDS, 4096, storage depth in 32-bit words (power of two).
- BASE_ADDR, 32'h0000_0000, byte address of word 0; must be aligned to MEM_WORDS*4.
- FIRST_WAIT, 1, wait cycles inserted on a NONSEQ beat (0..15).
- SEQ_WAIT, 0, wait cycles inserted on a SEQ beat (0..15).

Ports:
- hclk  in  1  clock
- hrst  in  1  synchronous active-high reset
- hsel  in  1  slave select
- haddr  in  32  byte address
- htrans  in  2  IDLE=0, BUSY=1, NONSEQ=2, SEQ=3
- hwrite  in  1  1=write
- hsize  in  3  0=byte, 1=half, 2=word; larger values are illegal
- hburst  in  3  burst type; informational, addresses are taken from haddr
- hwdata  in  32  write data (data phase)
- hready  in  1  bus-level ready (mux output)
- hreadyout  out  1  slave ready
- hresp  out  1  0=OKAY, 1=ERROR
- hrdata  out  32  read data, valid when hreadyout=1 in a read data phase
- load_en  in  1  backdoor preload write strobe; ignored while a data phase is active
- load_addr  in  log2(MEM_WORDS)  backdoor word index
- load_data  in  32  backdoor word

Behaviour:
- Reset is synchronous active-high:
  - hreadyout=1, hresp=0, hrdata=0.
  - FSM returns to IDLE; wait counter and captured address-phase registers are cleared.
  - Memory contents are not cleared.
  - Reset asserted mid-transfer aborts the transfer; no memory write occurs.
- Transfer accept: at posedge when hsel & hready & htrans[1].
  - On accept, capture haddr, hwrite and hsize.
  - Load the wait counter with FIRST_WAIT (NONSEQ) or SEQ_WAIT (SEQ).
- IDLE or BUSY with hsel & hready: OKAY response with zero wait; no state change.
- Error check at accept. ERROR is raised if any of the following hold:
  - address outside [BASE_ADDR, BASE_ADDR+MEM_WORDS*4);
  - hsize>2;
  - misalignment: hsize=1 with haddr[0]=1, or hsize=2 with haddr[1:0]≠0.
- FSM states:
  - IDLE:
    - accept legal with wait>0 → WAIT;
    - accept legal with wait=0 → DATA;
    - accept illegal → ERR1.
  - WAIT: hreadyout=0; the counter decrements each cycle; at counter=1 → DATA.
  - DATA: hreadyout=1, hresp=0; the beat completes this cycle.
    - A new accept in the same cycle follows the IDLE rules (pipelined).
    - No accept → IDLE.
  - ERR1: hreadyout=0, hresp=1 → ERR2.
  - ERR2: hreadyout=1, hresp=1. Accept is evaluated as in DATA. Per AHB, the master normally drives IDLE here, but any accept is honoured.
- Latency:
  - Read data appears in the cycle after accept + wait cycles.
  - With 0 waits, back-to-back beats complete every cycle.
  - A 4-beat burst with FIRST_WAIT=1, SEQ_WAIT=0 completes in 5 data-phase cycles.
- Read data:
  - hrdata is registered and loaded on the cycle entering DATA with mem[(addr-BASE_ADDR)>>2].
  - It always returns the full word, regardless of hsize.
  - hrdata holds its last value outside read DATA cycles.
- Write:
  - In the DATA cycle, hwdata is written under byte enables derived from the captured hsize/addr[1:0]: byte → 1 lane; half → lanes {1:0} or {3:2}; word → all lanes.
  - No write occurs on ERROR.
- Read-after-write hazard: if a read's DATA entry coincides with the completing write to the same word, hrdata returns the merged (post-write) word.
- Backdoor: load_en writes load_data at the next posedge when the FSM is in IDLE. load_en in other states is dropped.

Test Plan:
- Preload mem[0..3]=32'h11,22,33,44; FIRST_WAIT=1; single NONSEQ read of 0x4 → 1 cycle hreadyout=0, then hreadyout=1 with hrdata=32'h22, hresp=0.
- WRAP4 read starting 0x8 (addresses 0x8,0xC,0x0,0x4), SEQ_WAIT=0 → hrdata 33,44,11,22 on 4 consecutive ready cycles after the first wait.
- Byte write 0xAB to 0x5, then word read of 0x4 with 0 waits → hrdata=32'h0000AB22 (bypass path exercised).
- Read of BASE_ADDR+MEM_WORDS*4 → cycle1 hreadyout=0/hresp=1, cycle2 hreadyout=1/hresp=1; memory unchanged.
- Halfword write with haddr[0]=1 → ERROR two-cycle response; subsequent read of that word shows the old value.
- Assert hrst during a WAIT of a write → next cycle hreadyout=1, hresp=0; target word unchanged; a new read then completes normally.
